// File: rtl/lcd1602_driver.sv
// HD44780 16x2 character LCD driver in 8-bit write-only mode. Runs the power-up init,
// then redraws both rows from a per-frame snapshot whenever the input row images change.
module lcd1602_driver #(
  parameter int CLK_DIV    = 2,
  parameter int INIT_WAIT  = 10,
  parameter int CMD_WAIT   = 3,
  parameter int CLEAR_WAIT = 6
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    POWERUP, INIT, ADDR1, ROW1, ADDR2, ROW2, DONE, IDLE
  } state_t;

  typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

  state_t         state_reg;
  phase_t         phase_reg;
  logic [15:0]    cnt_reg;
  logic [1:0]     init_idx_reg;
  logic [3:0]     char_idx_reg;
  logic [255:0]   snapshot_reg;
  logic [15:0]    hold_last;

  assign lcd_rw = 1'b0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Char 0 sits in the top byte, so index i maps to bit offset (15-i)*8.
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] idx);
    return row[{~idx, 3'b000} +: 8];
  endfunction

  // The clear command needs a longer settle time than every other byte.
  always_comb begin
    hold_last = 16'(CMD_WAIT - 1);
    if (state_reg == INIT && lcd_data == 8'h01)
      hold_last = 16'(CLEAR_WAIT - 1);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_reg    <= POWERUP;
      phase_reg    <= SETUP;
      cnt_reg      <= '0;
      init_idx_reg <= '0;
      char_idx_reg <= '0;
      snapshot_reg <= '0;
      lcd_en       <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_data     <= 8'h00;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        POWERUP: begin
          if (cnt_reg == 16'(INIT_WAIT - 1)) begin
            cnt_reg      <= '0;
            state_reg    <= INIT;
            phase_reg    <= SETUP;
            init_idx_reg <= 2'd0;
            lcd_rs       <= 1'b0;
            lcd_data     <= init_cmd(2'd0);
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        IDLE: begin
          if ({top, bottom} != snapshot_reg) begin
            snapshot_reg <= {top, bottom};
            busy         <= 1'b1;
            state_reg    <= ADDR1;
            phase_reg    <= SETUP;
            cnt_reg      <= '0;
            lcd_rs       <= 1'b0;
            lcd_data     <= 8'h80;
          end
        end

        default: begin
          // Shared byte engine for INIT/ADDR1/ROW1/ADDR2/ROW2.
          case (phase_reg)
            SETUP: begin
              if (cnt_reg == 16'(CLK_DIV - 1)) begin
                cnt_reg   <= '0;
                phase_reg <= PULSE;
                lcd_en    <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 16'd1;
              end
            end

            PULSE: begin
              if (cnt_reg == 16'(CLK_DIV - 1)) begin
                cnt_reg   <= '0;
                phase_reg <= HOLD;
                lcd_en    <= 1'b0;
              end else begin
                cnt_reg <= cnt_reg + 16'd1;
              end
            end

            default: begin
              if (cnt_reg == hold_last) begin
                cnt_reg   <= '0;
                phase_reg <= SETUP;
                case (state_reg)
                  INIT: begin
                    if (init_idx_reg == 2'd3) begin
                      snapshot_reg <= {top, bottom};
                      state_reg    <= ADDR1;
                      lcd_rs       <= 1'b0;
                      lcd_data     <= 8'h80;
                    end else begin
                      init_idx_reg <= init_idx_reg + 2'd1;
                      lcd_data     <= init_cmd(init_idx_reg + 2'd1);
                    end
                  end
                  ADDR1: begin
                    state_reg    <= ROW1;
                    char_idx_reg <= 4'd0;
                    lcd_rs       <= 1'b1;
                    lcd_data     <= row_char(snapshot_reg[255:128], 4'd0);
                  end
                  ROW1: begin
                    char_idx_reg <= char_idx_reg + 4'd1;
                    if (char_idx_reg == 4'd15) begin
                      state_reg <= ADDR2;
                      lcd_rs    <= 1'b0;
                      lcd_data  <= 8'hC0;
                    end else begin
                      lcd_data <= row_char(snapshot_reg[255:128], char_idx_reg + 4'd1);
                    end
                  end
                  ADDR2: begin
                    state_reg    <= ROW2;
                    char_idx_reg <= 4'd0;
                    lcd_rs       <= 1'b1;
                    lcd_data     <= row_char(snapshot_reg[127:0], 4'd0);
                  end
                  default: begin
                    char_idx_reg <= char_idx_reg + 4'd1;
                    if (char_idx_reg == 4'd15) begin
                      state_reg  <= DONE;
                      frame_done <= 1'b1;
                    end else begin
                      lcd_data <= row_char(snapshot_reg[127:0], char_idx_reg + 4'd1);
                    end
                  end
                endcase
              end else begin
                cnt_reg <= cnt_reg + 16'd1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
